// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//
// Drives a matrix-vector product through an external A-lane MAC engine. Each
// pass streams the J-element vector together with A matrix rows (packed into
// one A*64-bit word per element), waits for the MAC result, and writes it to
// the result RAM at the pass index. P = ceil(I/A) passes make up one job.
//
// Optional feature macro: MAC_SEQ_WATCHDOG_EN
//   defined   : a watchdog aborts a pass after TIMEOUT cycles in WAIT without
//               beta_tvalid, sets err (sticky until the next accepted start)
//               and ends the job with a done pulse.
//   undefined : err is tied low and WAIT lasts until beta_tvalid arrives.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      job request pulse (accepted only when idle)
//   busy, done, err            job in progress / one-cycle completion / watchdog
//   v_rd_en, v_addr, v_rdata   vector RAM read port (1-cycle read latency)
//   m_rd_en, m_addr, m_rdata   matrix RAM read port (1-cycle read latency)
//   vinput, vinput_tvalid,
//   vinput_tlast               vector stream to the MAC
//   M_row, M_row_tvalid,
//   M_row_tlast                matrix-row stream to the MAC
//   beta_tvalid, beta          MAC result
//   res_wr_en, res_addr,
//   res_wdata                  result RAM write port
// -----------------------------------------------------------------------------
module mac_sequencer #(
    parameter  int J       = 14,
    parameter  int I       = 7,
    parameter  int A       = 2,
    parameter  int TIMEOUT = 1024,
    localparam int P       = (I + A - 1) / A,
    localparam int KW      = (J > 1) ? $clog2(J) : 1,
    localparam int MW      = (P * J > 1) ? $clog2(P * J) : 1,
    localparam int PW      = (P > 1) ? $clog2(P) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            v_rd_en,
    output logic [KW-1:0]   v_addr,
    input  logic [63:0]     v_rdata,
    output logic            m_rd_en,
    output logic [MW-1:0]   m_addr,
    input  logic [A*64-1:0] m_rdata,
    output logic [63:0]     vinput,
    output logic            vinput_tvalid,
    output logic            vinput_tlast,
    output logic [A*64-1:0] M_row,
    output logic            M_row_tvalid,
    output logic            M_row_tlast,
    input  logic            beta_tvalid,
    input  logic [A*64-1:0] beta,
    output logic            res_wr_en,
    output logic [PW-1:0]   res_addr,
    output logic [A*64-1:0] res_wdata
);

    if (J < 1 || I < 1 || A < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("mac_sequencer: J, I, A and TIMEOUT must all be at least 1");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [PW-1:0]   p_q, p_d;
    logic [A*64-1:0] res_wdata_q, res_wdata_d;
    // Stream valid/last are the read enables delayed by the RAM latency.
    logic            vld_q, vld_d;
    logic            last_q, last_d;

    wire issue   = (state_q == S_ISSUE);
    wire k_final = (k_q == KW'(J - 1));
    wire p_final = (p_q == PW'(P - 1));

`ifdef MAC_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        res_wdata_d = res_wdata_q;
        vld_d       = issue;
        last_d      = issue && k_final;
`ifdef MAC_SEQ_WATCHDOG_EN
        err_d       = err_q;
        // Non-WAIT states hold the counter at zero, so it is clear on entry.
        wd_d        = (state_q == S_WAIT) ? wd_q + 1'b1 : '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = '0;
                    p_d     = '0;
`ifdef MAC_SEQ_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                if (k_final) begin
                    k_d     = '0;
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (beta_tvalid) begin
                    res_wdata_d = beta;
                    state_d     = S_WRITE;
                end
`ifdef MAC_SEQ_WATCHDOG_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_WRITE: begin
                if (p_final) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + 1'b1;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            p_q         <= '0;
            res_wdata_q <= '0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            res_wdata_q <= res_wdata_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

`ifdef MAC_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign v_rd_en   = issue;
    assign m_rd_en   = issue;
    assign v_addr    = issue ? k_q : '0;
    assign m_addr    = issue ? MW'(p_q) * MW'(J) + MW'(k_q) : '0;

    // RAM data passes straight through; gating keeps the streams at zero
    // whenever no beat is valid (including during reset).
    assign vinput        = vld_q ? v_rdata : '0;
    assign M_row         = vld_q ? m_rdata : '0;
    assign vinput_tvalid = vld_q;
    assign M_row_tvalid  = vld_q;
    assign vinput_tlast  = last_q;
    assign M_row_tlast   = last_q;

    assign res_wr_en = (state_q == S_WRITE);
    assign res_addr  = res_wr_en ? p_q : '0;
    assign res_wdata = res_wdata_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_sequencer
//
// Self-checking bench for mac_sequencer. Vector/matrix RAMs are modelled with
// random contents and one-cycle latency; a MAC responder returns a random
// beta 10 cycles after each tlast. Expected fetch order, stream contents and
// result writes come from the job definition: fetch n of a job reads vector
// element n%J and matrix word n, beat n is last when n%J == J-1, and the
// result of pass p is written to address p.
// Build with MAC_SEQ_WATCHDOG_EN defined to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mac_sequencer;

    localparam int J   = 14;
    localparam int I   = 7;
    localparam int A   = 2;
    localparam int TMO = 16;
    localparam int P   = (I + A - 1) / A;
    localparam int KW  = (J > 1) ? $clog2(J) : 1;
    localparam int MW  = (P * J > 1) ? $clog2(P * J) : 1;
    localparam int PW  = (P > 1) ? $clog2(P) : 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            busy, done, err;
    logic            v_rd_en;
    logic [KW-1:0]   v_addr;
    logic [63:0]     v_rdata;
    logic            m_rd_en;
    logic [MW-1:0]   m_addr;
    logic [A*64-1:0] m_rdata;
    logic [63:0]     vinput;
    logic            vinput_tvalid, vinput_tlast;
    logic [A*64-1:0] M_row;
    logic            M_row_tvalid, M_row_tlast;
    logic            beta_tvalid;
    logic [A*64-1:0] beta;
    logic            res_wr_en;
    logic [PW-1:0]   res_addr;
    logic [A*64-1:0] res_wdata;

    mac_sequencer #(.J(J), .I(I), .A(A), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .err(err),
        .v_rd_en(v_rd_en), .v_addr(v_addr), .v_rdata(v_rdata),
        .m_rd_en(m_rd_en), .m_addr(m_addr), .m_rdata(m_rdata),
        .vinput(vinput), .vinput_tvalid(vinput_tvalid), .vinput_tlast(vinput_tlast),
        .M_row(M_row), .M_row_tvalid(M_row_tvalid), .M_row_tlast(M_row_tlast),
        .beta_tvalid(beta_tvalid), .beta(beta),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents
    logic [63:0]     vmem [0:J-1];
    logic [A*64-1:0] mmem [0:P*J-1];

    // One-cycle-latency RAM models
    always @(posedge clk) begin
        if (v_rd_en) v_rdata <= vmem[v_addr];
        if (m_rd_en) m_rdata <= mmem[m_addr];
    end

    typedef struct {
        logic [PW-1:0]   addr;
        logic [A*64-1:0] data;
    } wr_t;

    wr_t exp_wr[$];

    int nassert   = 0;
    int nfail     = 0;
    int cyc       = 0;
    int exp_idx   = 0;
    int prev_idx  = 0;
    bit prev_rd   = 1'b0;
    int beta_cnt  = 0;
    int beta_pass = 0;
    bit resp_en   = 1'b1;
    bit spur_en   = 1'b0;
    int n_writes  = 0;
    int n_done    = 0;
    int n_beats   = 0;
    int n_last    = 0;

    function automatic logic [A*64-1:0] rand_wide();
        logic [A*64-1:0] r;
        for (int i = 0; i < A * 2; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_memories();
        for (int i = 0; i < J; i++) vmem[i] = {$urandom, $urandom};
        for (int i = 0; i < P * J; i++) mmem[i] = rand_wide();
    endtask

    function automatic bit outputs_zero();
        logic [3*A*64+64+KW+MW+PW+10-1:0] all;
        all = {busy, done, err, v_rd_en, v_addr, m_rd_en, m_addr, vinput,
               vinput_tvalid, vinput_tlast, M_row, M_row_tvalid, M_row_tlast,
               res_wr_en, res_addr, res_wdata};
        return (all === '0);
    endfunction

    // One clock: drive the MAC responder, then check everything the DUT shows.
    task automatic cycle();
        wr_t e;
        bit  exp_last;
        @(negedge clk);
        cyc++;

        beta_tvalid = 1'b0;
        if (beta_cnt > 0) begin
            beta_cnt--;
            if (beta_cnt == 0) begin
                beta_tvalid = 1'b1;
                beta        = rand_wide();
                e.addr      = PW'(beta_pass);
                e.data      = beta;
                exp_wr.push_back(e);
                beta_pass++;
            end
        end else if (spur_en && v_rd_en === 1'b1) begin
            beta_tvalid = 1'b1;
            beta        = rand_wide();
        end

        // Stream: a beat follows each read enable by exactly one cycle.
        if (prev_rd) begin
            n_beats++;
            exp_last = ((prev_idx % J) == J - 1);
            nassert++;
            if (vinput_tvalid !== 1'b1 || M_row_tvalid !== 1'b1) begin
                nfail++;
                $display("FAIL stream_valid idx=%0d got v=%b m=%b exp 1/1", prev_idx, vinput_tvalid, M_row_tvalid);
            end
            nassert++;
            if (vinput !== vmem[prev_idx % J]) begin
                nfail++;
                $display("FAIL stream_vinput idx=%0d got=%h exp=%h", prev_idx, vinput, vmem[prev_idx % J]);
            end
            nassert++;
            if (M_row !== mmem[prev_idx]) begin
                nfail++;
                $display("FAIL stream_mrow idx=%0d got=%h exp=%h", prev_idx, M_row, mmem[prev_idx]);
            end
            nassert++;
            if (vinput_tlast !== exp_last || M_row_tlast !== exp_last) begin
                nfail++;
                $display("FAIL stream_tlast idx=%0d got v=%b m=%b exp=%b", prev_idx, vinput_tlast, M_row_tlast, exp_last);
            end
        end else begin
            nassert++;
            if ({vinput_tvalid, M_row_tvalid, vinput_tlast, M_row_tlast} !== 4'b0000) begin
                nfail++;
                $display("FAIL stream_idle cyc=%0d got tvalid/tlast=%b%b%b%b exp 0000", cyc,
                         vinput_tvalid, M_row_tvalid, vinput_tlast, M_row_tlast);
            end
        end
        if (prev_rd && vinput_tlast === 1'b1) begin
            n_last++;
            if (resp_en) beta_cnt = 10;
        end

        // Read port: fetches must follow the job order 0 .. P*J-1.
        nassert++;
        if (v_rd_en !== m_rd_en) begin
            nfail++;
            $display("FAIL rd_en_pair cyc=%0d got v=%b m=%b exp equal", cyc, v_rd_en, m_rd_en);
        end
        if (v_rd_en === 1'b1) begin
            nassert++;
            if (exp_idx >= P * J) begin
                nfail++;
                $display("FAIL rd_overrun got fetch %0d exp at most %0d fetches", exp_idx, P * J);
            end else if (v_addr !== KW'(exp_idx % J) || m_addr !== MW'(exp_idx)) begin
                nfail++;
                $display("FAIL rd_addr got v=%0d m=%0d exp v=%0d m=%0d", v_addr, m_addr, exp_idx % J, exp_idx);
            end
            prev_rd  = 1'b1;
            prev_idx = exp_idx;
            exp_idx++;
        end else begin
            prev_rd = 1'b0;
        end

        // Result writes are matched against the betas the responder produced.
        if (res_wr_en === 1'b1) begin
            n_writes++;
            nassert++;
            if (exp_wr.size() == 0) begin
                nfail++;
                $display("FAIL write_unexpected got addr=%0d data=%h exp no write", res_addr, res_wdata);
            end else begin
                e = exp_wr.pop_front();
                if (res_addr !== e.addr || res_wdata !== e.data) begin
                    nfail++;
                    $display("FAIL write_data got addr=%0d data=%h exp addr=%0d data=%h",
                             res_addr, res_wdata, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic launch();
        exp_idx   = 0;
        beta_pass = 0;
        beta_cnt  = 0;
        exp_wr.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        nassert++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            nfail++;
            $display("FAIL launch got busy=%b err=%b exp busy=1 err=0", busy, err);
        end
    endtask

    task automatic finish_job(input int w0, input int d0, input int b0, input int l0, input bit restart);
        bit got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start = restart && ($urandom_range(0, 3) == 0);
            cycle();
            nassert++;
            if (busy !== 1'b1) begin
                nfail++;
                $display("FAIL busy_in_job cyc=%0d got=%b exp=1", cyc, busy);
            end
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        nassert++;
        if (!got) begin
            nfail++;
            $display("FAIL job_timeout got no done exp done within 3000 cycles");
        end
        nassert++;
        if (n_writes - w0 != P || n_done - d0 != 1 || err !== 1'b0) begin
            nfail++;
            $display("FAIL job_totals got writes=%0d dones=%0d err=%b exp %0d/1/0", n_writes - w0, n_done - d0, err, P);
        end
        nassert++;
        if (n_beats - b0 != P * J || n_last - l0 != P || exp_idx != P * J || exp_wr.size() != 0) begin
            nfail++;
            $display("FAIL job_stream got beats=%0d lasts=%0d fetches=%0d pending=%0d exp %0d/%0d/%0d/0",
                     n_beats - b0, n_last - l0, exp_idx, exp_wr.size(), P * J, P, P * J);
        end
        cycle();
        nassert++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL after_done got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic run_job(input bit spur, input bit restart);
        int w0 = n_writes;
        int d0 = n_done;
        int b0 = n_beats;
        int l0 = n_last;
        spur_en = spur;
        launch();
        finish_job(w0, d0, b0, l0, restart);
        spur_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        beta_tvalid = 1'b0;
        beta        = '0;
        cycle();
        cycle();
        nassert++;
        if (!outputs_zero()) begin
            nfail++;
            $display("FAIL reset_outputs got busy=%b done=%b res_wdata=%h exp all zero", busy, done, res_wdata);
        end
        rst_n = 1'b1;
        cycle();
        nassert++;
        if (busy !== 1'b0 || n_writes != 0) begin
            nfail++;
            $display("FAIL idle_after_reset got busy=%b writes=%0d exp 0/0", busy, n_writes);
        end
    endtask

    task automatic test_reset_mid_job();
        int  w0;
        int  d0;
        int  l0 = n_last;
        bit  got = 1'b0;
        resp_en = 1'b1;
        launch();
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (n_last - l0 == 2) begin
                got = 1'b1;
                break;
            end
        end
        nassert++;
        if (!got) begin
            nfail++;
            $display("FAIL midreset_reach got lasts=%0d exp 2", n_last - l0);
        end
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        beta_cnt = 0;
        exp_wr.delete();
        #1;
        nassert++;
        if (!outputs_zero()) begin
            nfail++;
            $display("FAIL midreset_outputs got busy=%b v_rd_en=%b res_wdata=%h exp all zero", busy, v_rd_en, res_wdata);
        end
        cycle();
        rst_n = 1'b1;
        w0 = n_writes;
        d0 = n_done;
        for (int c = 0; c < 30; c++) cycle();
        nassert++;
        if (n_writes != w0 || n_done != d0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_quiet got writes=%0d dones=%0d busy=%b exp 0/0/0", n_writes - w0, n_done - d0, busy);
        end
        run_job(1'b0, 1'b0);
    endtask

`ifdef MAC_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int w0 = n_writes;
        int d0 = n_done;
        int last_rd = -1;
        int err_cyc = -1;
        int done_cyc = -1;
        resp_en = 1'b0;
        launch();
        last_rd = cyc;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (v_rd_en === 1'b1) last_rd = cyc;
            if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        // WAIT occupies TMO cycles after the final fetch; DONE follows.
        nassert++;
        if (done_cyc != last_rd + TMO + 1 || err_cyc != done_cyc) begin
            nfail++;
            $display("FAIL watchdog_timing got done@%0d err@%0d exp both @%0d", done_cyc, err_cyc, last_rd + TMO + 1);
        end
        nassert++;
        if (n_writes != w0 || n_done - d0 != 1 || exp_idx != J) begin
            nfail++;
            $display("FAIL watchdog_job got writes=%0d dones=%0d fetches=%0d exp 0/1/%0d", n_writes - w0, n_done - d0, exp_idx, J);
        end
        cycle();
        nassert++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL watchdog_sticky got err=%b busy=%b exp 1/0", err, busy);
        end
        resp_en = 1'b1;
        run_job(1'b0, 1'b0);
    endtask
`else
    task automatic test_no_watchdog();
        int  w0 = n_writes;
        int  d0 = n_done;
        int  b0 = n_beats;
        int  l0 = n_last;
        bit  stuck = 1'b1;
        resp_en = 1'b0;
        launch();
        for (int c = 0; c < 100 && n_last == l0; c++) cycle();
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) stuck = 1'b0;
        end
        nassert++;
        if (!stuck || n_writes != w0 || n_done != d0 || exp_idx != J) begin
            nfail++;
            $display("FAIL wait_forever got stuck=%b writes=%0d dones=%0d fetches=%0d exp 1/0/0/%0d",
                     stuck, n_writes - w0, n_done - d0, exp_idx, J);
        end
        resp_en  = 1'b1;
        beta_cnt = 1;
        finish_job(w0, d0, b0, l0, 1'b0);
    endtask
`endif

    initial begin
        fill_memories();
        test_reset();
        run_job(1'b0, 1'b0);  // test_basic
        run_job(1'b0, 1'b1);  // test_start_while_busy
        fill_memories();
        run_job(1'b0, 1'b0);  // test_stream with fresh data
        run_job(1'b1, 1'b0);  // test_spurious_beta
        test_reset_mid_job();
`ifdef MAC_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
